// File: rtl/c17v3_pipe_bist.sv
// rtl/c17v3_pipe_bist.sv - WIDTH-lane 3-stage pipelined C17V3 core with LFSR/MISR self-test
module c17v3_pipe_bist #(
  parameter int          WIDTH      = 4,
  parameter int          N_PATTERNS = 64,
  parameter logic [31:0] LFSR_SEED  = 32'hACE1_0001
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] g1,
  input  logic [WIDTH-1:0] g2,
  input  logic [WIDTH-1:0] g3,
  input  logic [WIDTH-1:0] g4,
  input  logic [WIDTH-1:0] g5,
  output logic             out_valid,
  output logic [WIDTH-1:0] g6,
  output logic [WIDTH-1:0] g7,
  input  logic             bist_start,
  input  logic [15:0]      sig_golden,
  output logic             bist_busy,
  output logic             bist_done,
  output logic             bist_pass,
  output logic [15:0]      misr_sig
);

  localparam int DW  = 2 * WIDTH;
  localparam int NCH = (DW + 15) / 16;

  typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;

  state_t      state, state_d;
  logic        start_run, inject, cnt_clr;
  logic [31:0] cnt;
  logic [31:0] lfsr;
  logic [15:0] misr, misr_d, fold;
  logic [16*NCH-1:0] padded;

  logic [WIDTH-1:0] a1, a2, a3, a4, a5;
  logic             s1_in_valid;

  logic             s1_valid, s1_tag, s2_valid, s2_tag, s3_valid, s3_tag;
  logic [WIDTH-1:0] s1_w1, s1_w2, s1_g3, s1_g4;
  logic [WIDTH-1:0] s2_w2, s2_w3, s2_w4;
  logic [WIDTH-1:0] s3_g6, s3_g7;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_d;
  end

  always_comb begin
    state_d   = state;
    start_run = 1'b0;
    inject    = 1'b0;
    cnt_clr   = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (bist_start) begin
          state_d   = RUN;
          start_run = 1'b1;
        end
      end
      RUN: begin
        inject = 1'b1;
        if (cnt == 32'(N_PATTERNS - 1)) begin
          state_d = FLUSH;
          cnt_clr = 1'b1;
        end
      end
      FLUSH: begin
        if (cnt == 32'd2) state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign in_ready  = ((state == IDLE) || (state == DONE)) && !bist_start;
  assign bist_busy = (state == RUN) || (state == FLUSH);
  assign bist_done = (state == DONE);
  assign bist_pass = (state == DONE) && (misr == sig_golden);
  assign misr_sig  = misr;
  assign out_valid = s3_valid & ~s3_tag;

  // Pattern count in RUN, drain count in FLUSH.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                    cnt <= '0;
    else if (start_run || cnt_clr)              cnt <= '0;
    else if ((state == RUN) || (state == FLUSH)) cnt <= cnt + 32'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)            lfsr <= LFSR_SEED;
    else if (start_run) lfsr <= LFSR_SEED;
    else if (inject)    lfsr <= {lfsr[30:0], lfsr[31] ^ lfsr[21] ^ lfsr[1] ^ lfsr[0]};
  end

  always_comb begin
    for (int i = 0; i < WIDTH; i++) begin
      a1[i] = inject ? lfsr[5*i+0] : g1[i];
      a2[i] = inject ? lfsr[5*i+1] : g2[i];
      a3[i] = inject ? lfsr[5*i+2] : g3[i];
      a4[i] = inject ? lfsr[5*i+3] : g4[i];
      a5[i] = inject ? lfsr[5*i+4] : g5[i];
    end
  end

  assign s1_in_valid = inject | (in_valid & in_ready);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0; s1_tag <= 1'b0;
      s2_valid <= 1'b0; s2_tag <= 1'b0;
      s3_valid <= 1'b0; s3_tag <= 1'b0;
      s1_w1 <= '0; s1_w2 <= '0; s1_g3 <= '0; s1_g4 <= '0;
      s2_w2 <= '0; s2_w3 <= '0; s2_w4 <= '0;
      s3_g6 <= '0; s3_g7 <= '0;
      g6    <= '0; g7    <= '0;
    end else begin
      s1_valid <= s1_in_valid;
      s1_tag   <= inject;
      s1_w1    <= ~(a5 & a2);
      s1_w2    <= ~(a5 & a1);
      s1_g3    <= a3;
      s1_g4    <= a4;
      s2_valid <= s1_valid;
      s2_tag   <= s1_tag;
      s2_w2    <= s1_w2;
      s2_w3    <= ~(s1_w1 & s1_g4);
      s2_w4    <= ~(s1_w1 & s1_g3);
      s3_valid <= s2_valid;
      s3_tag   <= s2_tag;
      s3_g6    <= ~(s2_w2 & s2_w3);
      s3_g7    <= ~(s2_w4 & s2_w3);
      // Visible results only track normal samples so they hold across BIST.
      if (s2_valid && !s2_tag) begin
        g6 <= ~(s2_w2 & s2_w3);
        g7 <= ~(s2_w4 & s2_w3);
      end
    end
  end

  always_comb begin
    padded         = '0;
    padded[DW-1:0] = {s3_g7, s3_g6};
    fold           = '0;
    for (int c = 0; c < NCH; c++) fold = fold ^ padded[16*c +: 16];
    misr_d = {misr[14:0], 1'b0} ^ (misr[15] ? 16'h1021 : 16'h0000) ^ fold;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                       misr <= '0;
    else if (start_run)            misr <= '0;
    else if (s3_valid && s3_tag)   misr <= misr_d;
  end

endmodule

// File: tb/tb_c17v3_pipe_bist.sv
// tb/tb_c17v3_pipe_bist.sv - self-checking bench for c17v3_pipe_bist
module tb_c17v3_pipe_bist;
  localparam int          W    = 4;
  localparam int          NP   = 64;
  localparam logic [31:0] SEED = 32'hACE1_0001;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid, in_ready, out_valid;
  logic [W-1:0] g1, g2, g3, g4, g5, g6, g7;
  logic         bist_start, bist_busy, bist_done, bist_pass;
  logic [15:0]  sig_golden, misr_sig;

  c17v3_pipe_bist #(.WIDTH(W), .N_PATTERNS(NP), .LFSR_SEED(SEED)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .g1(g1), .g2(g2), .g3(g3), .g4(g4), .g5(g5),
    .out_valid(out_valid), .g6(g6), .g7(g7),
    .bist_start(bist_start), .sig_golden(sig_golden),
    .bist_busy(bist_busy), .bist_done(bist_done), .bist_pass(bist_pass),
    .misr_sig(misr_sig)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int fails  = 0;
  int ncyc   = 0;
  int ov_count = 0;

  typedef struct packed {
    int           due;
    logic [W-1:0] e6;
    logic [W-1:0] e7;
  } exp_t;
  exp_t         exp_q[$];
  logic [W-1:0] last6 = '0, last7 = '0;
  logic [15:0]  sig_model;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Combinational C17 evaluated lane by lane: returns {g7, g6}.
  function automatic logic [2*W-1:0] c17(input logic [W-1:0] a1, a2, a3, a4, a5);
    logic [W-1:0] r6, r7;
    logic w1, w2, w3, w4;
    for (int i = 0; i < W; i++) begin
      w1 = !(a5[i] && a2[i]);
      w2 = !(a5[i] && a1[i]);
      w3 = !(w1 && a4[i]);
      w4 = !(w1 && a3[i]);
      r6[i] = !(w2 && w3);
      r7[i] = !(w4 && w3);
    end
    return {r7, r6};
  endfunction

  function automatic logic [15:0] bist_sig();
    logic [31:0]    l = SEED;
    logic [15:0]    m = '0;
    logic [W-1:0]   b1, b2, b3, b4, b5;
    logic [2*W-1:0] r;
    for (int p = 0; p < NP; p++) begin
      for (int i = 0; i < W; i++) begin
        b1[i] = l[5*i];   b2[i] = l[5*i+1]; b3[i] = l[5*i+2];
        b4[i] = l[5*i+3]; b5[i] = l[5*i+4];
      end
      r = c17(b1, b2, b3, b4, b5);
      m = {m[14:0], 1'b0} ^ (m[15] ? 16'h1021 : 16'h0000) ^ 16'(r);
      l = {l[30:0], l[31] ^ l[21] ^ l[1] ^ l[0]};
    end
    return m;
  endfunction

  // Per-cycle compare against the expectation queue, then record acceptances.
  always begin
    exp_t e;
    logic [2*W-1:0] r;
    @(negedge clk);
    ncyc++;
    if (rst) begin
      exp_q.delete();
      last6 = '0;
      last7 = '0;
    end else begin
      if (out_valid) ov_count++;
      if (exp_q.size() > 0 && exp_q[0].due == ncyc) begin
        e = exp_q.pop_front();
        check("out_valid_due", 32'(out_valid), 32'd1);
        check("g6_result", 32'(g6), 32'(e.e6));
        check("g7_result", 32'(g7), 32'(e.e7));
        last6 = e.e6;
        last7 = e.e7;
      end else begin
        check("out_valid_idle", 32'(out_valid), 32'd0);
        check("g6_hold", 32'(g6), 32'(last6));
        check("g7_hold", 32'(g7), 32'(last7));
      end
    end
    #4;
    if (!rst && in_valid && in_ready) begin
      r = c17(g1, g2, g3, g4, g5);
      exp_q.push_back('{due: ncyc + 3, e6: r[W-1:0], e7: r[2*W-1:W]});
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic run_bist(input logic [15:0] golden, input bit poke, input bit exp_pass);
    int busy = 0;
    int rdy_bad = 0;
    step();
    sig_golden = golden;
    bist_start = 1'b1;
    in_valid   = 1'b1;
    #1 check("in_ready_on_start", 32'(in_ready), 32'd0);
    step();
    bist_start = 1'b0;
    in_valid   = 1'b0;
    for (int k = 0; k < 300; k++) begin
      if (bist_done) break;
      if (bist_busy) busy++;
      if (in_ready) rdy_bad++;
      step();
      bist_start = poke && (k == 20);
    end
    bist_start = 1'b0;
    check("bist_busy_cycles", 32'(busy), 32'(NP + 3));
    check("in_ready_during_bist", 32'(rdy_bad), 32'd0);
    check("bist_done", 32'(bist_done), 32'd1);
    check("bist_pass", 32'(bist_pass), 32'(exp_pass));
    check("misr_sig", 32'(misr_sig), 32'(sig_model));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    sig_model  = bist_sig();
    rst        = 1'b1;
    in_valid   = 1'b0;
    bist_start = 1'b0;
    sig_golden = '0;
    {g1, g2, g3, g4, g5} = '0;
    step();
    step();
    rst = 1'b0;
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_busy", 32'(bist_busy), 32'd0);
    check("rst_done", 32'(bist_done), 32'd0);
    check("rst_pass", 32'(bist_pass), 32'd0);
    check("rst_g6", 32'(g6), 32'd0);
    check("rst_g7", 32'(g7), 32'd0);
    check("rst_misr", 32'(misr_sig), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);

    step();
    in_valid = 1'b1; {g1, g2, g3, g4, g5} = {5{4'hF}};
    step();
    in_valid = 1'b0;
    repeat (4) step();
    check("ones_g6", 32'(g6), 32'hF);
    check("ones_g7", 32'(g7), 32'h0);

    in_valid = 1'b1; {g1, g2, g3, g4, g5} = '0;
    step();
    in_valid = 1'b0;
    repeat (4) step();
    check("zeros_g6", 32'(g6), 32'h0);
    check("zeros_g7", 32'(g7), 32'h0);

    in_valid = 1'b1;
    g1 = 4'h0; g2 = 4'h0; g3 = 4'h1; g4 = 4'h1; g5 = 4'h1;
    step();
    in_valid = 1'b0;
    repeat (4) step();
    check("lane0_g6", 32'(g6), 32'h1);
    check("lane0_g7", 32'(g7), 32'h1);

    ov_count = 0;
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1;
      g1 = 4'(i); g2 = 4'(i * 3); g3 = 4'(i * 5 + 1); g4 = 4'(i * 7 + 2); g5 = 4'(~i);
      step();
    end
    in_valid = 1'b0;
    repeat (6) step();
    check("stream_out_valid_count", 32'(ov_count), 32'd10);

    ov_count = 0;
    run_bist(sig_model, 1'b1, 1'b1);
    check("bist_no_out_valid", 32'(ov_count), 32'd0);
    run_bist(sig_model ^ 16'h0001, 1'b0, 1'b0);

    ov_count = 0;
    in_valid = 1'b1;
    g1 = 4'h3; g2 = 4'hA; g3 = 4'h5; g4 = 4'hC; g5 = 4'h9;
    step();
    g1 = 4'hE; g2 = 4'h1; g3 = 4'h7; g4 = 4'h2; g5 = 4'hB;
    run_bist(sig_model, 1'b0, 1'b1);
    check("inflight_results", 32'(ov_count), 32'd2);

    step();
    bist_start = 1'b1;
    step();
    bist_start = 1'b0;
    repeat (10) step();
    rst = 1'b1;
    #1;
    check("abort_busy", 32'(bist_busy), 32'd0);
    check("abort_misr", 32'(misr_sig), 32'd0);
    check("abort_out_valid", 32'(out_valid), 32'd0);
    check("abort_done", 32'(bist_done), 32'd0);
    step();
    rst = 1'b0;
    run_bist(sig_model, 1'b0, 1'b1);

    repeat (3) step();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
